// File: rtl/vga_filter_pipe.sv
// vga_filter_pipe: three-stage, free-running pixel filter for a VGA stream.
//   S1: register pixel, sync and settings; form r+g+b.
//   S2: gray = floor(sum/3) and saturating per-channel brightness.
//   S3: mode mux; invalid pixel slots are forced to black.
// Settings (mode, bright, thresh) are sampled only on frame_start and ride
// down the pipe with their pixel, so a frame never mixes modes.
// Optional feature: define VGA_FILTER_THRESH_EN to enable mode 5 (threshold);
// without it, mode 5 passes pixels through and no thresh hardware exists.
module vga_filter_pipe #(
  parameter int COLOR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   in_valid,
  input  logic                   in_hsync,
  input  logic                   in_vsync,
  input  logic [3*COLOR_W-1:0]   in_rgb,
  input  logic [2:0]             mode,
  input  logic [COLOR_W:0]       bright,
  input  logic [COLOR_W-1:0]     thresh,
  output logic                   out_valid,
  output logic                   out_hsync,
  output logic                   out_vsync,
  output logic [3*COLOR_W-1:0]   out_rgb,
  output logic [2:0]             active_mode
);

  localparam int LATENCY = 3;

  typedef logic [COLOR_W-1:0]   chan_t;
  typedef logic [COLOR_W+1:0]   sum_t;
  typedef logic [3*COLOR_W-1:0] pix_t;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_INV    = 3'd1,
    MODE_GRAY   = 3'd2,
    MODE_BRIGHT = 3'd3,
    MODE_SWAP   = 3'd4,
    MODE_THRESH = 3'd5,
    MODE_RSVD6  = 3'd6,
    MODE_RSVD7  = 3'd7
  } mode_e;

  // c + bright evaluated at COLOR_W+2 bits; bit W+1 = negative, bit W = overflow
  function automatic chan_t sat_add(input chan_t c, input logic [COLOR_W:0] b);
    sum_t s;
    s = {2'b00, c} + {b[COLOR_W], b};
    if (s[COLOR_W+1])    return '0;
    else if (s[COLOR_W]) return '1;
    else                 return s[COLOR_W-1:0];
  endfunction

  // Latched settings and the values effective for the current input slot
  mode_e              mode_q, mode_d;
  logic [COLOR_W:0]   bright_q, bright_d;

  // Delay lines for valid and syncs
  logic [LATENCY-1:0] vld_q, hs_q, vs_q;

  // Stage 1
  pix_t               rgb1_q;
  sum_t               sum1_q, sum1_d;
  mode_e              mode1_q;
  logic [COLOR_W:0]   bright1_q;

  // Stage 2
  pix_t               rgb2_q, brt2_d, brt2_q;
  chan_t              gray2_q, gray2_d;
  mode_e              mode2_q;

  // Stage 3
  pix_t               rgb3_q, rgb3_d;

`ifdef VGA_FILTER_THRESH_EN
  localparam chan_t THRESH_RST = chan_t'(1 << (COLOR_W-1));
  chan_t              thresh_q, thresh_d, thresh1_q, thresh2_q;

  // Threshold setting follows the same frame_start sampling as the others
  always_comb begin
    thresh_d = frame_start ? thresh : thresh_q;
  end

  // Threshold register and its pipeline copies
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thresh_q  <= THRESH_RST;
      thresh1_q <= THRESH_RST;
      thresh2_q <= THRESH_RST;
    end else begin
      thresh_q  <= thresh_d;
      thresh1_q <= thresh_d;
      thresh2_q <= thresh1_q;
    end
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  // Settings in force for this slot: a frame_start pixel uses the new values
  always_comb begin
    mode_d   = frame_start ? mode_e'(mode) : mode_q;
    bright_d = frame_start ? bright : bright_q;
  end

  // Settings registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= MODE_PASS;
      bright_q <= '0;
    end else begin
      mode_q   <= mode_d;
      bright_q <= bright_d;
    end
  end

  // Valid and sync delay lines; syncs idle high in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], in_valid};
      hs_q  <= {hs_q[LATENCY-2:0], in_hsync};
      vs_q  <= {vs_q[LATENCY-2:0], in_vsync};
    end
  end

  // S1 channel sum
  always_comb begin
    sum1_d = {2'b00, in_rgb[3*COLOR_W-1:2*COLOR_W]}
           + {2'b00, in_rgb[2*COLOR_W-1:COLOR_W]}
           + {2'b00, in_rgb[COLOR_W-1:0]};
  end

  // S2 gray and brightness
  always_comb begin
    gray2_d = chan_t'(sum1_q / sum_t'(3));
    brt2_d  = {sat_add(rgb1_q[3*COLOR_W-1:2*COLOR_W], bright1_q),
               sat_add(rgb1_q[2*COLOR_W-1:COLOR_W],   bright1_q),
               sat_add(rgb1_q[COLOR_W-1:0],           bright1_q)};
  end

  // S3 mode mux; empty slots output black
  always_comb begin
    rgb3_d = '0;
    if (vld_q[LATENCY-2]) begin
      case (mode2_q)
        MODE_INV:    rgb3_d = ~rgb2_q;
        MODE_GRAY:   rgb3_d = {gray2_q, gray2_q, gray2_q};
        MODE_BRIGHT: rgb3_d = brt2_q;
        MODE_SWAP:   rgb3_d = {rgb2_q[COLOR_W-1:0], rgb2_q[2*COLOR_W-1:COLOR_W],
                               rgb2_q[3*COLOR_W-1:2*COLOR_W]};
`ifdef VGA_FILTER_THRESH_EN
        MODE_THRESH: rgb3_d = (gray2_q >= thresh2_q) ? '1 : '0;
`endif
        default:     rgb3_d = rgb2_q;
      endcase
    end
  end

  // Pipeline data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb1_q    <= '0;
      sum1_q    <= '0;
      mode1_q   <= MODE_PASS;
      bright1_q <= '0;
      rgb2_q    <= '0;
      gray2_q   <= '0;
      brt2_q    <= '0;
      mode2_q   <= MODE_PASS;
      rgb3_q    <= '0;
    end else begin
      rgb1_q    <= in_rgb;
      sum1_q    <= sum1_d;
      mode1_q   <= mode_d;
      bright1_q <= bright_d;
      rgb2_q    <= rgb1_q;
      gray2_q   <= gray2_d;
      brt2_q    <= brt2_d;
      mode2_q   <= mode1_q;
      rgb3_q    <= rgb3_d;
    end
  end

  assign out_valid   = vld_q[LATENCY-1];
  assign out_hsync   = hs_q[LATENCY-1];
  assign out_vsync   = vs_q[LATENCY-1];
  assign out_rgb     = rgb3_q;
  assign active_mode = mode_q;

endmodule
